dummy_xif_commit_tracker: RTL and testbench
===========================================

Name: dummy_xif_commit_tracker

Overview:
- Per-instruction commit/kill scheduler between the XIF commit interface and the result path of the dummy coprocessor.
- Tracks every accepted XIF ID through issue, commit and result.
- Results of committed IDs are forwarded to the XIF result interface; results of killed IDs are drained and dropped; results of not-yet-committed IDs are held.
- Replaces the global coprocessor flush with per-ID kill handling that complies with the XIF spec.

Parameters:
- DATA_WIDTH, 32, width of result data.
- XIF_ID_WIDTH, 1, width of the XIF instruction ID. The tracker has NUM_ID = 2**XIF_ID_WIDTH entries.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- issue_valid_i  in  1  XIF issue_valid
- issue_ready_i  in  1  XIF issue_ready as driven by the decoder
- issue_accept_i  in  1  XIF issue_resp.accept
- issue_id_i  in  XIF_ID_WIDTH  XIF issue_req.id
- issue_stall_o  out  1  ID of the current issue request is still in flight; the wrapper ANDs its inverse into issue_ready
- commit_valid_i  in  1  XIF commit_valid
- commit_id_i  in  XIF_ID_WIDTH  XIF commit.id
- commit_kill_i  in  1  XIF commit.commit_kill
- cp_valid_i  in  1  coprocessor result valid
- cp_ready_o  out  1  coprocessor result ready
- cp_id_i  in  XIF_ID_WIDTH  result tag ID
- cp_rd_i  in  5  result destination register
- cp_data_i  in  DATA_WIDTH  result data
- result_valid_o  out  1  XIF result_valid
- result_ready_i  in  1  XIF result_ready
- result_id_o  out  XIF_ID_WIDTH  XIF result.id
- result_rd_o  out  5  XIF result.rd
- result_data_o  out  DATA_WIDTH  XIF result.data
- inflight_cnt_o  out  XIF_ID_WIDTH+1  number of non-IDLE entries

Behaviour:
- Per-entry state (2 bits) takes one of four values: IDLE, ISSUED, COMMITTED, KILLED. After reset all entries are IDLE.
- Issue handshake: `issue_valid_i & issue_ready_i & issue_accept_i & ~issue_stall_o`.
  - `issue_stall_o = issue_valid_i & (state[issue_id_i] != IDLE)`, combinational.
- Entry transitions, all registered:
  - IDLE -> ISSUED on issue handshake.
  - ISSUED -> COMMITTED on `commit_valid_i & ~commit_kill_i` with a matching ID.
  - ISSUED -> KILLED on `commit_valid_i & commit_kill_i` with a matching ID.
  - COMMITTED or KILLED -> IDLE on cp handshake (`cp_valid_i & cp_ready_o`) with a matching `cp_id_i`.
- Commit for an IDLE, COMMITTED or KILLED entry is ignored and causes no state change.
- Result routing is a function of `state[cp_id_i]`:
  - COMMITTED: forward. `cp_ready_o` follows the output stage ready.
  - KILLED: `cp_ready_o = 1`, `result_valid_o = 0`, result dropped in the same cycle.
  - ISSUED: hold. `cp_ready_o = 0`, `result_valid_o = 0`.
  - IDLE (protocol error): `cp_ready_o = 1`, result dropped.
- Simultaneous events:
  - Commit and result for the same ID in the same cycle: the commit lands this cycle; the result is evaluated on the pre-commit state (held) and forwarded or dropped on the next cycle.
  - Release and reissue of the same ID in the same cycle: the stall uses the current state, so reissue is accepted one cycle later.
  - Issue, commit and release on different IDs in the same cycle are all applied.
- `inflight_cnt_o`: +1 on issue handshake, -1 on release, unchanged when both occur in the same cycle. It never exceeds NUM_ID, because a full tracker stalls every ID.
- Output data, ID and rd pass through unchanged; no arithmetic is applied.
- Reset outputs:
  - `result_valid_o = 0`, `cp_ready_o = 0`, `issue_stall_o = 0`, `inflight_cnt_o = 0`.
  - Data, ID and rd are 0 when the output register is present.
- Reset mid-operation: all entries return to IDLE immediately (asynchronous); in-flight results are lost.
- Latency: 0 cycles from cp to XIF result without the optional feature.
- The tracker relies on XIF ordering; it does not reorder results.

Optional Feature:
- Macro: DUMMY_XIF_TRACKER_OUTREG_EN.
- Defined:
  - A full-throughput pipeline register sits between the routing logic and the XIF result outputs.
  - Ready into the register is `~valid_q | result_ready_i`.
  - Latency is 1 cycle; back-to-back results are accepted every cycle while `result_ready_i = 1`.
  - The entry is released when the result is captured into the register.
- Undefined:
  - Outputs are combinational from the cp inputs.
  - `cp_ready_o = result_ready_i` for COMMITTED entries.
  - The entry is released on the XIF result handshake.

Decomposition:
- dummy_pkg gains:
  - `trk_state_e`, the four-value entry state enum (IDLE, ISSUED, COMMITTED, KILLED).
  - `trk_result_t`, a packed struct of id, rd and data.
- Sub-module `dummy_xif_result_slice`: a valid/ready register parameterised on the payload type, instantiated only under the macro.

Test Plan:
- Issue ID0, commit ID0 (kill=0), cp result ID0 data 0xDEADBEEF rd 5 -> result_valid_o=1 with id 0, rd 5, data 0xDEADBEEF; `inflight_cnt_o` goes 1->0 after the handshake.
- Issue ID1, commit ID1 with kill=1, cp result ID1 -> `cp_ready_o=1` and `result_valid_o` stays 0; entry returns to IDLE and `inflight_cnt_o=0`.
- Issue ID0, cp result ID0 three cycles before the commit -> `cp_ready_o=0` for those 3 cycles; result forwarded on the cycle after the commit.
- Issue ID0 (in flight), then issue_valid with ID0 again -> `issue_stall_o=1` until ID0 is released; the reissue is accepted in the following cycle.
- Two IDs in flight (width 1), `result_ready_i=0` for 4 cycles -> both held with `cp_ready_o=0`; with `result_ready_i=1` both drain in order, and with OUTREG_EN the first data appears 1 cycle later.
- Assert `rst_ni=0` mid-flight with 2 entries -> `inflight_cnt_o=0` and `result_valid_o=0` immediately; after reset, issue ID0 is accepted without stall.

Source files
------------

// File: rtl/dummy_pkg.sv
// Shared types for the dummy coprocessor XIF commit tracker.
// trk_result_t is the payload view at the default widths (1-bit ID, 32-bit data).
package dummy_pkg;

    typedef enum logic [1:0] {
        TRK_IDLE      = 2'd0,
        TRK_ISSUED    = 2'd1,
        TRK_COMMITTED = 2'd2,
        TRK_KILLED    = 2'd3
    } trk_state_e;

    localparam int TRK_ID_WIDTH   = 1;
    localparam int TRK_RD_WIDTH   = 5;
    localparam int TRK_DATA_WIDTH = 32;

    typedef struct packed {
        logic [TRK_ID_WIDTH-1:0]   id;
        logic [TRK_RD_WIDTH-1:0]   rd;
        logic [TRK_DATA_WIDTH-1:0] data;
    } trk_result_t;

endpackage

// File: rtl/dummy_xif_result_slice.sv
// Full-throughput valid/ready register stage, parameterised on the payload type.
// A new beat is accepted whenever the stage is empty or is being drained this cycle.
module dummy_xif_result_slice #(
    parameter type T = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic valid_i,
    output logic ready_o,
    input  T     data_i,
    output logic valid_o,
    input  logic ready_i,
    output T     data_o
);

    logic valid_q;
    T     data_q;

    assign ready_o = ~valid_q | ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (ready_o) begin
            valid_q <= valid_i;
            if (valid_i) data_q <= data_i;
        end
    end

endmodule

// File: rtl/dummy_xif_commit_tracker.sv
// Per-ID commit/kill tracker between XIF commit and the coprocessor result path.
// Optional output register: DUMMY_XIF_TRACKER_OUTREG_EN.
module dummy_xif_commit_tracker
    import dummy_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int XIF_ID_WIDTH = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    issue_valid_i,
    input  logic                    issue_ready_i,
    input  logic                    issue_accept_i,
    input  logic [XIF_ID_WIDTH-1:0] issue_id_i,
    output logic                    issue_stall_o,
    input  logic                    commit_valid_i,
    input  logic [XIF_ID_WIDTH-1:0] commit_id_i,
    input  logic                    commit_kill_i,
    input  logic                    cp_valid_i,
    output logic                    cp_ready_o,
    input  logic [XIF_ID_WIDTH-1:0] cp_id_i,
    input  logic [4:0]              cp_rd_i,
    input  logic [DATA_WIDTH-1:0]   cp_data_i,
    output logic                    result_valid_o,
    input  logic                    result_ready_i,
    output logic [XIF_ID_WIDTH-1:0] result_id_o,
    output logic [4:0]              result_rd_o,
    output logic [DATA_WIDTH-1:0]   result_data_o,
    output logic [XIF_ID_WIDTH:0]   inflight_cnt_o
);

    localparam int NUM_ID = 2**XIF_ID_WIDTH;

    // Handshakes: a beat transfers on a cycle where valid and ready are both high;
    // valid never waits on ready, and ready may look at valid and the beat's ID.
    trk_state_e                state_q [NUM_ID];
    trk_state_e                cp_state;
    logic [XIF_ID_WIDTH:0]     cnt_q;
    logic                      issue_hs;
    logic                      commit_hit;
    logic                      fwd_valid;
    logic                      sink_ready;
    logic                      release_en;

    assign cp_state      = state_q[cp_id_i];
    assign issue_stall_o = issue_valid_i & (state_q[issue_id_i] != TRK_IDLE);
    assign issue_hs      = issue_valid_i & issue_ready_i & issue_accept_i & ~issue_stall_o;
    assign commit_hit    = commit_valid_i & (state_q[commit_id_i] == TRK_ISSUED);
    assign fwd_valid     = cp_valid_i & (cp_state == TRK_COMMITTED);

    // Killed and idle (stray) results are swallowed; issued ones wait for their commit.
    always_comb begin
        cp_ready_o = 1'b0;
        if (cp_valid_i) begin
            unique case (cp_state)
                TRK_COMMITTED: cp_ready_o = sink_ready;
                TRK_ISSUED:    cp_ready_o = 1'b0;
                default:       cp_ready_o = 1'b1;
            endcase
        end
    end

    assign release_en = cp_valid_i & cp_ready_o &
                        ((cp_state == TRK_COMMITTED) | (cp_state == TRK_KILLED));

    // Issue, commit and release can only ever target entries in distinct states,
    // so the three writes below never collide on the same ID.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_ID; i++) state_q[i] <= TRK_IDLE;
            cnt_q <= '0;
        end else begin
            if (issue_hs)   state_q[issue_id_i]  <= TRK_ISSUED;
            if (commit_hit) state_q[commit_id_i] <= commit_kill_i ? TRK_KILLED : TRK_COMMITTED;
            if (release_en) state_q[cp_id_i]     <= TRK_IDLE;
            if (issue_hs & ~release_en)      cnt_q <= cnt_q + 1'b1;
            else if (~issue_hs & release_en) cnt_q <= cnt_q - 1'b1;
        end
    end

    assign inflight_cnt_o = cnt_q;

`ifdef DUMMY_XIF_TRACKER_OUTREG_EN
    typedef struct packed {
        logic [XIF_ID_WIDTH-1:0] id;
        logic [4:0]              rd;
        logic [DATA_WIDTH-1:0]   data;
    } result_t;

    result_t fwd_payload;
    result_t out_payload;

    assign fwd_payload = '{id: cp_id_i, rd: cp_rd_i, data: cp_data_i};

    dummy_xif_result_slice #(
        .T (result_t)
    ) u_result_slice (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (fwd_valid),
        .ready_o (sink_ready),
        .data_i  (fwd_payload),
        .valid_o (result_valid_o),
        .ready_i (result_ready_i),
        .data_o  (out_payload)
    );

    assign result_id_o   = out_payload.id;
    assign result_rd_o   = out_payload.rd;
    assign result_data_o = out_payload.data;
`else
    assign sink_ready     = result_ready_i;
    assign result_valid_o = fwd_valid;
    assign result_id_o    = cp_id_i;
    assign result_rd_o    = cp_rd_i;
    assign result_data_o  = cp_data_i;
`endif

endmodule

// File: tb/tb_dummy_xif_commit_tracker.sv
// Self-checking bench for dummy_xif_commit_tracker (both DUMMY_XIF_TRACKER_OUTREG_EN builds).
module tb_dummy_xif_commit_tracker;

  localparam int DW  = 32;
  localparam int IW  = 1;
  localparam int NID = 2;
  localparam int PW  = IW + 5 + DW;
  localparam int M_IDLE = 0, M_ISS = 1, M_COM = 2, M_KIL = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          issue_valid = 0, issue_ready = 0, issue_accept = 0;
  logic [IW-1:0] issue_id = '0;
  logic          issue_stall;
  logic          commit_valid = 0, commit_kill = 0;
  logic [IW-1:0] commit_id = '0;
  logic          cp_valid = 0;
  logic          cp_ready;
  logic [IW-1:0] cp_id = '0;
  logic [4:0]    cp_rd = '0;
  logic [DW-1:0] cp_data = '0;
  logic          result_valid;
  logic          result_ready = 0;
  logic [IW-1:0] result_id;
  logic [4:0]    result_rd;
  logic [DW-1:0] result_data;
  logic [IW:0]   inflight_cnt;

  // clock / reset block
  always #5 clk = ~clk;

  dummy_xif_commit_tracker #(.DATA_WIDTH(DW), .XIF_ID_WIDTH(IW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .issue_valid_i(issue_valid), .issue_ready_i(issue_ready), .issue_accept_i(issue_accept),
    .issue_id_i(issue_id), .issue_stall_o(issue_stall),
    .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
    .cp_valid_i(cp_valid), .cp_ready_o(cp_ready), .cp_id_i(cp_id), .cp_rd_i(cp_rd),
    .cp_data_i(cp_data),
    .result_valid_o(result_valid), .result_ready_i(result_ready), .result_id_o(result_id),
    .result_rd_o(result_rd), .result_data_o(result_data),
    .inflight_cnt_o(inflight_cnt)
  );

  int checks = 0;
  int errors = 0;

  // behavioural model: abstract status of every ID plus the output-stage contents
  int mst[NID];
  logic [PW-1:0] exp_q[$];

  logic          s_rv, s_ready, s_stall;
  logic [IW:0]   s_cnt;
  logic [DW-1:0] s_data;
  logic [4:0]    s_rd;
  logic [IW-1:0] s_id;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_cnt();
    int n = 0;
    for (int i = 0; i < NID; i++) if (mst[i] != M_IDLE) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NID; i++) mst[i] = M_IDLE;
    exp_q.delete();
  endtask

  // driver tasks
  task automatic drive_idle();
    issue_valid = 0; issue_ready = 0; issue_accept = 0; issue_id = '0;
    commit_valid = 0; commit_kill = 0; commit_id = '0;
    cp_valid = 0; cp_id = '0; cp_rd = '0; cp_data = '0;
    result_ready = 1;
  endtask

  task automatic drive_issue(input int id);
    issue_valid = 1; issue_ready = 1; issue_accept = 1; issue_id = IW'(id);
  endtask

  task automatic drive_commit(input int id, input bit kill);
    commit_valid = 1; commit_id = IW'(id); commit_kill = kill;
  endtask

  task automatic drive_cp(input int id, input logic [4:0] rd, input logic [DW-1:0] data);
    cp_valid = 1; cp_id = IW'(id); cp_rd = rd; cp_data = data;
  endtask

  task automatic drive_random();
    issue_valid  = ($urandom_range(0, 99) < 50);
    issue_ready  = ($urandom_range(0, 99) < 80);
    issue_accept = ($urandom_range(0, 99) < 80);
    issue_id     = IW'($urandom_range(0, NID-1));
    commit_valid = ($urandom_range(0, 99) < 40);
    commit_kill  = ($urandom_range(0, 99) < 30);
    commit_id    = IW'($urandom_range(0, NID-1));
    cp_valid     = ($urandom_range(0, 99) < 60);
    cp_id        = IW'($urandom_range(0, NID-1));
    cp_rd        = 5'($urandom_range(0, 31));
    cp_data      = $urandom();
    result_ready = ($urandom_range(0, 99) < 70);
  endtask

  // scoreboard step: inputs are set at the negedge; check, then advance the model at posedge
  task automatic cycle();
    int cur, ns[NID];
    bit sink_rdy, exp_ready, exp_stall, exp_rv, fwd_hs, rel, iss_hs;
    #1;
    s_rv = result_valid; s_ready = cp_ready; s_stall = issue_stall; s_cnt = inflight_cnt;
    s_data = result_data; s_rd = result_rd; s_id = result_id;
    cur = mst[cp_id];
    exp_stall = issue_valid && (mst[issue_id] != M_IDLE);
`ifdef DUMMY_XIF_TRACKER_OUTREG_EN
    sink_rdy = (exp_q.size() == 0) || result_ready;
    exp_rv   = (exp_q.size() != 0);
`else
    sink_rdy = result_ready;
    exp_rv   = cp_valid && (cur == M_COM);
`endif
    exp_ready = (cur == M_COM) ? sink_rdy : (cur != M_ISS);
    chk("issue_stall", 64'(issue_stall), 64'(exp_stall));
    chk("inflight_cnt", 64'(inflight_cnt), 64'(model_cnt()));
    chk("result_valid", 64'(result_valid), 64'(exp_rv));
    if (cp_valid) chk("cp_ready", 64'(cp_ready), 64'(exp_ready));
`ifdef DUMMY_XIF_TRACKER_OUTREG_EN
    if (exp_q.size() != 0) chk("result_payload", 64'({result_id, result_rd, result_data}), 64'(exp_q[0]));
`else
    if (exp_rv) chk("result_payload", 64'({result_id, result_rd, result_data}), 64'({cp_id, cp_rd, cp_data}));
`endif
    fwd_hs = cp_valid && (cur == M_COM) && sink_rdy;
    rel    = cp_valid && exp_ready && (cur == M_COM || cur == M_KIL);
    iss_hs = issue_valid && issue_ready && issue_accept && !exp_stall;
    ns = mst;
    if (iss_hs) ns[issue_id] = M_ISS;
    if (commit_valid && mst[commit_id] == M_ISS) ns[commit_id] = commit_kill ? M_KIL : M_COM;
    if (rel) ns[cp_id] = M_IDLE;
    @(posedge clk);
`ifdef DUMMY_XIF_TRACKER_OUTREG_EN
    if (exp_q.size() != 0 && result_ready) void'(exp_q.pop_front());
    if (fwd_hs) exp_q.push_back({cp_id, cp_rd, cp_data});
`endif
    mst = ns;
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    drive_idle();
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    model_reset();
    drive_idle();
    @(negedge clk);
    #1;
    chk("reset_result_valid", 64'(result_valid), 64'd0);
    chk("reset_cp_ready", 64'(cp_ready), 64'd0);
    chk("reset_stall", 64'(issue_stall), 64'd0);
    chk("reset_cnt", 64'(inflight_cnt), 64'd0);
`ifdef DUMMY_XIF_TRACKER_OUTREG_EN
    chk("reset_data", 64'(result_data), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1;

    // committed result is forwarded
    drive_idle(); drive_issue(0); cycle();
    drive_idle(); drive_commit(0, 0); cycle();
    chk("t1_cnt_inflight", 64'(s_cnt), 64'd1);
    drive_idle(); drive_cp(0, 5'd5, 32'hDEADBEEF); cycle();
    chk("t1_cp_ready", 64'(s_ready), 64'd1);
`ifdef DUMMY_XIF_TRACKER_OUTREG_EN
    chk("t1_no_valid_yet", 64'(s_rv), 64'd0);
    drive_idle(); cycle();
`endif
    chk("t1_valid", 64'(s_rv), 64'd1);
    chk("t1_data", 64'(s_data), 64'hDEADBEEF);
    chk("t1_rd", 64'(s_rd), 64'd5);
    chk("t1_id", 64'(s_id), 64'd0);
    idle_cycles(1);
    chk("t1_cnt_done", 64'(s_cnt), 64'd0);

    // killed result is drained
    drive_idle(); drive_issue(1); cycle();
    drive_idle(); drive_commit(1, 1); cycle();
    drive_idle(); drive_cp(1, 5'd7, 32'h12345678); cycle();
    chk("t2_cp_ready", 64'(s_ready), 64'd1);
    chk("t2_no_valid", 64'(s_rv), 64'd0);
    idle_cycles(1);
    chk("t2_cnt", 64'(s_cnt), 64'd0);
    chk("t2_no_valid_after", 64'(s_rv), 64'd0);

    // result ahead of commit is held
    drive_idle(); drive_issue(0); cycle();
    for (int i = 0; i < 3; i++) begin
      drive_idle(); drive_cp(0, 5'd3, 32'hCAFE0001); cycle();
      chk("t3_held", 64'(s_ready), 64'd0);
    end
    drive_idle(); drive_cp(0, 5'd3, 32'hCAFE0001); drive_commit(0, 0); cycle();
    chk("t3_held_at_commit", 64'(s_ready), 64'd0);
    drive_idle(); drive_cp(0, 5'd3, 32'hCAFE0001); cycle();
    chk("t3_fwd_ready", 64'(s_ready), 64'd1);
    idle_cycles(2);

    // reissue of an in-flight ID stalls until the cycle after release
    drive_idle(); drive_issue(0); cycle();
    drive_idle(); drive_issue(0); cycle();
    chk("t4_stall_a", 64'(s_stall), 64'd1);
    drive_idle(); drive_issue(0); drive_commit(0, 0); cycle();
    chk("t4_stall_b", 64'(s_stall), 64'd1);
    drive_idle(); drive_issue(0); drive_cp(0, 5'd1, 32'h0000_0042); cycle();
    chk("t4_stall_release", 64'(s_stall), 64'd1);
    drive_idle(); drive_issue(0); cycle();
    chk("t4_reissue", 64'(s_stall), 64'd0);
    idle_cycles(1);
    chk("t4_cnt", 64'(s_cnt), 64'd1);
    drive_idle(); drive_commit(0, 1); cycle();
    drive_idle(); drive_cp(0, 5'd0, 32'h0); cycle();
    idle_cycles(2);

    // two committed results held by back-pressure, then drained in order
    drive_idle(); drive_issue(0); cycle();
    drive_idle(); drive_issue(1); drive_commit(0, 0); cycle();
    drive_idle(); drive_commit(1, 0); cycle();
    chk("t5_full_cnt", 64'(s_cnt), 64'd2);
    for (int i = 0; i < 4; i++) begin
      drive_idle(); result_ready = 0; drive_cp(0, 5'd10, 32'h11111111); cycle();
`ifndef DUMMY_XIF_TRACKER_OUTREG_EN
      chk("t5_backpressure", 64'(s_ready), 64'd0);
`endif
    end
    drive_idle(); drive_cp(0, 5'd10, 32'h11111111); cycle();
`ifndef DUMMY_XIF_TRACKER_OUTREG_EN
    chk("t5_first_data", 64'(s_data), 64'h11111111);
`endif
    drive_idle(); drive_cp(1, 5'd11, 32'h22222222); cycle();
`ifdef DUMMY_XIF_TRACKER_OUTREG_EN
    chk("t5_first_data_late", 64'(s_data), 64'h11111111);
`else
    chk("t5_second_data", 64'(s_data), 64'h22222222);
`endif
    idle_cycles(2);
    chk("t5_cnt_done", 64'(s_cnt), 64'd0);

    // asynchronous reset with two entries in flight
    drive_idle(); drive_issue(0); cycle();
    drive_idle(); drive_issue(1); drive_commit(0, 0); cycle();
    drive_idle(); drive_cp(0, 5'd2, 32'h0BAD0BAD);
    #2 rst_n = 0;
    #1;
    chk("t6_rst_cnt", 64'(inflight_cnt), 64'd0);
    chk("t6_rst_valid", 64'(result_valid), 64'd0);
    model_reset();
    drive_idle();
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    drive_idle(); drive_issue(0); cycle();
    chk("t6_issue_after_rst", 64'(s_stall), 64'd0);
    idle_cycles(1);
    chk("t6_cnt_after_rst", 64'(s_cnt), 64'd1);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      cycle();
    end
    idle_cycles(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
